// File: rtl/counter_btn_controller_pkg.sv
// Shared encodings for the counter push-button controller.
package counter_btn_controller_pkg;

    // Controller state, also driven out on o_state.
    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_e;

    // Count direction after reset: up.
    localparam logic UPDOWN_RESET = 1'b1;

endpackage

// File: rtl/counter_btn_controller_btn_debounce.sv
// One button front end: synchroniser, stability debouncer and press-pulse generator.
// A button that is already held when reset is released does not produce a press;
// it has to be seen released at least once before a press is accepted.
module btn_debounce
    import counter_btn_controller_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   level_dly_q, level_dly_d;
    logic                   armed_q, armed_d;
    logic                   press_q, press_d;
    logic                   s_lvl;
    logic                   s_vld;

    assign s_lvl = sync_q[SYNC_STAGES-1];
    // vld marks when the synchroniser holds a real sample rather than reset zeros
    assign s_vld = vld_q[SYNC_STAGES-1];

    // Next-state logic: sync shift, stability counter, level update, edge detect
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], i_btn};
        vld_d       = {vld_q[SYNC_STAGES-2:0], 1'b1};
        cnt_d       = cnt_q;
        level_d     = level_q;
        if (s_lvl == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s_lvl;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        level_dly_d = level_q;
        armed_d     = armed_q | (s_vld & ~s_lvl & ~level_q);
        press_d     = level_q & ~level_dly_q & armed_q;
    end

    // State registers, all cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            vld_q       <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            armed_q     <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            vld_q       <= vld_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            armed_q     <= armed_d;
            press_q     <= press_d;
        end
    end

    assign o_level = level_q;
    assign o_press = press_q;

endmodule

// File: rtl/counter_btn_controller.sv
// Run/clear/direction sequencer for the 0..9999 up/down counter.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_STOP  | counter halted; run/clear presses accepted, mode toggles dir
//   ST_RUN   | counter enabled; only a run press (stop) is accepted
//   ST_CLEAR | clear request held until the next i_tick rising edge
//   2'b11    | illegal, recovers to ST_STOP on the next clk
module counter_btn_controller
    import counter_btn_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_clear,
    input  logic       btn_mode,
    input  logic       i_tick,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_updown,
    output logic [1:0] o_state
);

    logic       run_p, clear_p, mode_p;
    logic [2:0] unused_btn_level;

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_run),
        .o_level (unused_btn_level[0]),
        .o_press (run_p)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_clear),
        .o_level (unused_btn_level[1]),
        .o_press (clear_p)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_mode),
        .o_level (unused_btn_level[2]),
        .o_press (mode_p)
    );

    state_e state_q, state_d;
    logic   run_q, run_d;
    logic   clear_q, clear_d;
    logic   updown_q, updown_d;
    logic   tick_dly_q;
    logic   tick_rise;

    assign tick_rise = i_tick & ~tick_dly_q;

    // Transition logic; outputs are decoded from the next state so they register with it
    always_comb begin
        state_d  = state_q;
        updown_d = updown_q;
        case (state_q)
            ST_STOP: begin
                if (clear_p) begin
                    state_d = ST_CLEAR;
                end else if (run_p) begin
                    state_d = ST_RUN;
                end
                if (mode_p) begin
                    updown_d = ~updown_q;
                end
            end
            ST_RUN: begin
                if (run_p) begin
                    state_d = ST_STOP;
                end
            end
            ST_CLEAR: begin
                if (tick_rise) begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_STOP;
        endcase
        run_d   = (state_d == ST_RUN);
        clear_d = (state_d == ST_CLEAR);
    end

    // State, registered outputs and tick history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_STOP;
            run_q      <= 1'b0;
            clear_q    <= 1'b0;
            updown_q   <= UPDOWN_RESET;
            tick_dly_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            clear_q    <= clear_d;
            updown_q   <= updown_d;
            tick_dly_q <= i_tick;
        end
    end

    assign o_run    = run_q;
    assign o_clear  = clear_q;
    assign o_updown = updown_q;
    assign o_state  = state_q;

endmodule
